// File: rtl/sum_acc_pkg.sv
// Shared defaults and FSM state type for the burst sum accumulator.
package sum_acc_pkg;

    localparam int unsigned DefInW  = 5;
    localparam int unsigned DefAccW = 7;
    localparam int unsigned DefCount = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } sum_acc_state_t;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned sums per burst and holds the total until accepted.
// Define SUM_ACCUMULATOR_SAT_EN to saturate on overflow instead of wrapping.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int unsigned IN_W  = DefInW,
    parameter int unsigned ACC_W = DefAccW,
    parameter int unsigned COUNT = DefCount
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned SumW      = ACC_W + 1;
    localparam logic [7:0]  CountLast = 8'(COUNT);

    sum_acc_state_t state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             in_xfer;
    logic             out_xfer;
    logic [SumW-1:0]  sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_add;
    logic [7:0]       cnt_inc;
    logic             last;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign sum_ext  = {1'b0, acc_q} + SumW'(in_sum);
    assign carry    = sum_ext[ACC_W];
    assign cnt_inc  = cnt_q + 8'd1;
    assign last     = (cnt_inc == CountLast);

`ifdef SUM_ACCUMULATOR_SAT_EN
    assign acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_add = sum_ext[ACC_W-1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every transfer
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (in_xfer) state_d = ACCUM;
                ACCUM:   if (in_xfer && last) state_d = HOLD;
                HOLD:    if (out_xfer) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state_q != HOLD) && !clear;
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (in_xfer) begin
            if (state_q == IDLE) begin
                acc_d = ACC_W'(in_sum);
                cnt_d = 8'd1;
                ovf_d = 1'b0;
            end else begin
                acc_d = acc_add;
                cnt_d = cnt_inc;
                ovf_d = ovf_q | carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_total = acc_q;
    assign out_ovf   = ovf_q;

endmodule
